hc112_ctrl: RTL and testbench

- Command sequencer and arbiter for one dual JK flip-flop device (two channels, each with J, K, active-low S, active-low R and a clock).
- Two requesters (A, B) issue symbolic commands. The block arbitrates round-robin and generates the J/K/S/R setup and clock pulse for the addressed channel.
- After each command it reads back Q and reports pass/fail.
- Sits between the control logic and the flip-flop pair; it is the only driver of the device's inputs.

---
 rtl/hc112_ctrl_if.sv | 32 +++
 rtl/hc112_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hc112_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hc112_ctrl_if.sv
// Bundle between hc112_ctrl and its surroundings: two requester ports,
// status, and the pins of the dual JK flip-flop device.
interface hc112_ctrl_if;
  logic       req_a;
  logic [2:0] cmd_a;
  logic       ch_a;
  logic       ack_a;
  logic       err_a;
  logic       req_b;
  logic [2:0] cmd_b;
  logic       ch_b;
  logic       ack_b;
  logic       err_b;
  logic       busy;
  logic [7:0] err_cnt;
  logic       j1, k1, s1, r1, clk1;
  logic       j2, k2, s2, r2, clk2;
  logic       q1, q2;

  // master: requesters plus the flip-flop outputs feeding back
  modport master (
    output req_a, cmd_a, ch_a, req_b, cmd_b, ch_b, q1, q2,
    input  ack_a, err_a, ack_b, err_b, busy, err_cnt,
    input  j1, k1, s1, r1, clk1, j2, k2, s2, r2, clk2
  );

  modport slave (
    input  req_a, cmd_a, ch_a, req_b, cmd_b, ch_b, q1, q2,
    output ack_a, err_a, ack_b, err_b, busy, err_cnt,
    output j1, k1, s1, r1, clk1, j2, k2, s2, r2, clk2
  );
endinterface

// File: rtl/hc112_ctrl.sv
// Round-robin command sequencer for a dual JK flip-flop: drives J/K/S/R and
// the device clock for the granted channel, then reads Q back and reports.
module hc112_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2
) (
  input logic         clk,
  input logic         rst,
  hc112_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_CLKHI   = 3'd2;
  localparam logic [2:0] ST_CLKLO   = 3'd3;
  localparam logic [2:0] ST_ASSERT  = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;
  localparam logic [2:0] ST_CHECK   = 3'd6;

  localparam logic [2:0] CMD_HOLD   = 3'd0;
  localparam logic [2:0] CMD_LOAD0  = 3'd1;
  localparam logic [2:0] CMD_LOAD1  = 3'd2;
  localparam logic [2:0] CMD_TOGGLE = 3'd3;
  localparam logic [2:0] CMD_SET    = 3'd4;
  localparam logic [2:0] CMD_CLR    = 3'd5;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       ptr;
  logic       ch_q;
  logic       id_q;
  logic       exp_q;
  logic       ack_a, err_a, ack_b, err_b;
  logic [7:0] err_cnt;
  logic       j1, k1, s1, r1, ck1;
  logic       j2, k2, s2, r2, ck2;

  logic       grant, gnt_b, sel_ch, sel_q, live_q;
  logic [2:0] sel_cmd;
  logic       last_setup, last_pulse;
  logic       done, done_err, done_id;

  function automatic logic expected_q(input logic [2:0] cmd, input logic q);
    case (cmd)
      CMD_HOLD:   expected_q = q;
      CMD_LOAD0:  expected_q = 1'b0;
      CMD_LOAD1:  expected_q = 1'b1;
      CMD_TOGGLE: expected_q = ~q;
      CMD_SET:    expected_q = 1'b1;
      CMD_CLR:    expected_q = 1'b0;
      default:    expected_q = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    // Pointer only matters on a tie; 0 favours A, 1 favours B.
    gnt_b      = bus.req_b & (~bus.req_a | ptr);
    grant      = bus.req_a | bus.req_b;
    sel_cmd    = gnt_b ? bus.cmd_b : bus.cmd_a;
    sel_ch     = gnt_b ? bus.ch_b : bus.ch_a;
    sel_q      = sel_ch ? bus.q2 : bus.q1;
    live_q     = ch_q ? bus.q2 : bus.q1;
    last_setup = (cnt == SETUP_LAST);
    last_pulse = (cnt == PULSE_LAST);
    done       = 1'b0;
    done_err   = 1'b0;
    done_id    = id_q;
    case (state)
      ST_IDLE: if (grant && sel_cmd > CMD_CLR) begin
        done     = 1'b1;
        done_err = 1'b1;
        done_id  = gnt_b;
      end
      ST_CLKLO: if (last_pulse) begin
        done     = 1'b1;
        done_err = (live_q != exp_q);
      end
      ST_RELEASE: begin
        done     = 1'b1;
        done_err = (live_q != exp_q);
      end
      default: ;
    endcase
  end

  // Ack/Err are registered on the edge entering CHECK so they are high
  // exactly for the CHECK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      ptr     <= 1'b0;
      ch_q    <= 1'b0;
      id_q    <= 1'b0;
      exp_q   <= 1'b0;
      ack_a   <= 1'b0;
      err_a   <= 1'b0;
      ack_b   <= 1'b0;
      err_b   <= 1'b0;
      err_cnt <= 8'd0;
      j1 <= 1'b0; k1 <= 1'b0; s1 <= 1'b1; r1 <= 1'b1; ck1 <= 1'b0;
      j2 <= 1'b0; k2 <= 1'b0; s2 <= 1'b1; r2 <= 1'b1; ck2 <= 1'b0;
    end else begin
      ack_a <= done & ~done_id;
      ack_b <= done & done_id;
      err_a <= done & done_err & ~done_id;
      err_b <= done & done_err & done_id;
      if (done && done_err) err_cnt <= sat_inc(err_cnt);
      case (state)
        ST_IDLE: if (grant) begin
          ch_q  <= sel_ch;
          id_q  <= gnt_b;
          exp_q <= expected_q(sel_cmd, sel_q);
          cnt   <= 8'd0;
          if (sel_cmd <= CMD_TOGGLE) begin
            // J = cmd[1], K = cmd[0] for the four clocked commands
            state <= ST_SETUP;
            j1 <= ~sel_ch & sel_cmd[1];
            k1 <= ~sel_ch & sel_cmd[0];
            j2 <= sel_ch & sel_cmd[1];
            k2 <= sel_ch & sel_cmd[0];
          end else if (sel_cmd <= CMD_CLR) begin
            state <= ST_ASSERT;
            s1 <= ~(~sel_ch & ~sel_cmd[0]);
            r1 <= ~(~sel_ch & sel_cmd[0]);
            s2 <= ~(sel_ch & ~sel_cmd[0]);
            r2 <= ~(sel_ch & sel_cmd[0]);
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_SETUP: if (last_setup) begin
          state <= ST_CLKHI;
          cnt   <= 8'd0;
          ck1   <= ~ch_q;
          ck2   <= ch_q;
        end else begin
          cnt <= cnt + 8'd1;
        end
        ST_CLKHI: if (last_pulse) begin
          state <= ST_CLKLO;
          cnt   <= 8'd0;
          ck1   <= 1'b0;
          ck2   <= 1'b0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        ST_CLKLO: if (last_pulse) begin
          state <= ST_CHECK;
          j1 <= 1'b0; k1 <= 1'b0; j2 <= 1'b0; k2 <= 1'b0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        ST_ASSERT: if (last_pulse) begin
          state <= ST_RELEASE;
          s1 <= 1'b1; r1 <= 1'b1; s2 <= 1'b1; r2 <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
        ST_RELEASE: state <= ST_CHECK;
        ST_CHECK: begin
          state <= ST_IDLE;
          ptr   <= ~id_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack_a   = ack_a;
  assign bus.err_a   = err_a;
  assign bus.ack_b   = ack_b;
  assign bus.err_b   = err_b;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.err_cnt = err_cnt;
  assign bus.j1      = j1;
  assign bus.k1      = k1;
  assign bus.s1      = s1;
  assign bus.r1      = r1;
  assign bus.clk1    = ck1;
  assign bus.j2      = j2;
  assign bus.k2      = k2;
  assign bus.s2      = s2;
  assign bus.r2      = r2;
  assign bus.clk2    = ck2;

endmodule

// File: tb/tb_hc112_ctrl.sv
// Directed bench for hc112_ctrl with a behavioural dual JK flip-flop on the
// device pins; expected values are hand-derived from the command timing.
module tb_hc112_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n;

  hc112_ctrl_if bus ();

  hc112_ctrl #(.SETUP_CYC(2), .PULSE_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Device model: rising-edge JK with active-low async set/clear.
  logic q1m = 1'b0;
  logic q2m = 1'b0;
  logic stuck2 = 1'b0;

  always @(posedge bus.clk1 or negedge bus.s1 or negedge bus.r1) begin
    if (!bus.s1) q1m <= 1'b1;
    else if (!bus.r1) q1m <= 1'b0;
    else case ({bus.j1, bus.k1})
      2'b01:   q1m <= 1'b0;
      2'b10:   q1m <= 1'b1;
      2'b11:   q1m <= ~q1m;
      default: ;
    endcase
  end

  always @(posedge bus.clk2 or negedge bus.s2 or negedge bus.r2) begin
    if (!bus.s2) q2m <= 1'b1;
    else if (!bus.r2) q2m <= 1'b0;
    else case ({bus.j2, bus.k2})
      2'b01:   q2m <= 1'b0;
      2'b10:   q2m <= 1'b1;
      2'b11:   q2m <= ~q2m;
      default: ;
    endcase
  end

  assign bus.q1 = q1m;
  assign bus.q2 = stuck2 ? 1'b0 : q2m;

  logic [9:0] pins;
  assign pins = {bus.j1, bus.k1, bus.s1, bus.r1, bus.clk1,
                 bus.j2, bus.k2, bus.s2, bus.r2, bus.clk2};

  localparam logic [9:0] PINS_IDLE = 10'b00110_00110;

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from an idle block with no competing request; lat is
  // the number of edges from the grant edge to the Ack cycle.
  task automatic run_cmd(input logic side, input logic [2:0] cmd, input logic ch,
                         input int lat, input logic eerr, input string tag);
    int k;
    if (side) begin
      bus.req_b = 1'b1; bus.cmd_b = cmd; bus.ch_b = ch;
    end else begin
      bus.req_a = 1'b1; bus.cmd_a = cmd; bus.ch_a = ch;
    end
    cyc(1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    k = 0;
    while (!(bus.ack_a | bus.ack_b) && k < 20) begin
      cyc(1);
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_ack"}, 32'({bus.ack_a, bus.ack_b}), side ? 32'd1 : 32'd2);
    chk({tag, "_err"}, 32'(side ? bus.err_b : bus.err_a), 32'(eerr));
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    cyc(1);
    chk({tag, "_idle"}, 32'({bus.busy, bus.ack_a, bus.ack_b}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_a = 1'b0; bus.cmd_a = 3'd0; bus.ch_a = 1'b0;
    bus.req_b = 1'b0; bus.cmd_b = 3'd0; bus.ch_b = 1'b0;

    // Reset values
    cyc(2);
    chk("rst_pins", 32'(pins), 32'(PINS_IDLE));
    chk("rst_ack", 32'({bus.ack_a, bus.err_a, bus.ack_b, bus.err_b}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_errcnt", 32'(bus.err_cnt), 32'd0);
    rst = 1'b0;
    cyc(1);

    // LOAD1 on channel 1, pin sequence cycle by cycle
    bus.req_a = 1'b1; bus.cmd_a = 3'd2; bus.ch_a = 1'b0;
    cyc(1);
    chk("ld1_setup0", 32'(pins), 32'(10'b10110_00110));
    chk("ld1_busy", 32'(bus.busy), 32'd1);
    cyc(1);
    chk("ld1_setup1", 32'(pins), 32'(10'b10110_00110));
    cyc(1);
    chk("ld1_clkhi0", 32'(pins), 32'(10'b10111_00110));
    cyc(1);
    chk("ld1_clkhi1", 32'(pins), 32'(10'b10111_00110));
    cyc(1);
    chk("ld1_clklo0", 32'(pins), 32'(10'b10110_00110));
    cyc(1);
    chk("ld1_clklo1", 32'(pins), 32'(10'b10110_00110));
    chk("ld1_noack", 32'(bus.ack_a), 32'd0);
    cyc(1);
    chk("ld1_ack", 32'({bus.ack_a, bus.ack_b}), 32'd2);
    chk("ld1_err", 32'(bus.err_a), 32'd0);
    chk("ld1_pins", 32'(pins), 32'(PINS_IDLE));
    chk("ld1_q1", 32'(bus.q1), 32'd1);
    bus.req_a = 1'b0;
    cyc(1);
    chk("ld1_done", 32'({bus.busy, bus.ack_a}), 32'd0);

    // TOGGLE twice on channel 1
    run_cmd(1'b0, 3'd3, 1'b0, 6, 1'b0, "tog1");
    chk("tog1_q1", 32'(bus.q1), 32'd0);
    run_cmd(1'b0, 3'd3, 1'b0, 6, 1'b0, "tog2");
    chk("tog2_q1", 32'(bus.q1), 32'd1);
    chk("tog_errcnt", 32'(bus.err_cnt), 32'd0);

    // Reset returns pointer to A; both requesters CLR channel 2
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.req_a = 1'b1; bus.cmd_a = 3'd5; bus.ch_a = 1'b1;
    bus.req_b = 1'b1; bus.cmd_b = 3'd5; bus.ch_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.busy && n < 10) begin
        cyc(1);
        n++;
      end
      chk("arb_grant", 32'(n), 32'd1);
      chk("arb_r2_lo0", 32'(pins), 32'(10'b00110_00100));
      cyc(1);
      chk("arb_r2_lo1", 32'(pins), 32'(10'b00110_00100));
      cyc(1);
      chk("arb_release", 32'({pins, bus.ack_a, bus.ack_b}), 32'({PINS_IDLE, 2'b00}));
      cyc(1);
      chk("arb_order", 32'({bus.ack_a, bus.ack_b}), (k % 2 == 0) ? 32'd2 : 32'd1);
      chk("arb_err", 32'({bus.err_a, bus.err_b}), 32'd0);
      chk("arb_q2", 32'(bus.q2), 32'd0);
      if (k == 3) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
      cyc(1);
    end
    chk("arb_end_busy", 32'(bus.busy), 32'd0);

    // Q2 stuck at 0: LOAD1 fails readback, counter saturates
    stuck2 = 1'b1;
    run_cmd(1'b1, 3'd2, 1'b1, 6, 1'b1, "stuck");
    chk("stuck_cnt1", 32'(bus.err_cnt), 32'd1);
    for (int k = 0; k < 254; k++) run_cmd(1'b1, 3'd2, 1'b1, 6, 1'b1, "stuck");
    chk("stuck_cnt255", 32'(bus.err_cnt), 32'd255);
    run_cmd(1'b1, 3'd2, 1'b1, 6, 1'b1, "stuck");
    chk("stuck_sat", 32'(bus.err_cnt), 32'd255);
    stuck2 = 1'b0;

    // Illegal command: immediate Ack with Err, no pin activity
    bus.req_a = 1'b1; bus.cmd_a = 3'd7; bus.ch_a = 1'b0;
    cyc(1);
    chk("ill_ack", 32'({bus.ack_a, bus.err_a, bus.ack_b}), 32'b110);
    chk("ill_pins", 32'(pins), 32'(PINS_IDLE));
    chk("ill_cnt", 32'(bus.err_cnt), 32'd255);
    bus.req_a = 1'b0;
    cyc(1);
    chk("ill_done", 32'({bus.busy, bus.ack_a}), 32'd0);

    // Reset in CLKHI (pointer is B before this)
    bus.req_a = 1'b1; bus.cmd_a = 3'd1; bus.ch_a = 1'b0;
    cyc(3);
    chk("rmid_clkhi", 32'(bus.clk1), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_pins", 32'(pins), 32'(PINS_IDLE));
    chk("rmid_busy", 32'({bus.busy, bus.ack_a, bus.ack_b}), 32'd0);
    bus.req_a = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    chk("rmid_noack", 32'({bus.busy, bus.ack_a, bus.ack_b}), 32'd0);
    bus.req_a = 1'b1; bus.cmd_a = 3'd4; bus.ch_a = 1'b0;
    bus.req_b = 1'b1; bus.cmd_b = 3'd4; bus.ch_b = 1'b1;
    cyc(1);
    chk("rmid_ptr_a", 32'({bus.s1, bus.s2}), 32'b01);
    cyc(3);
    chk("rmid_ack_a", 32'({bus.ack_a, bus.err_a, bus.ack_b}), 32'b100);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    cyc(1);
    chk("rmid_q1", 32'(bus.q1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
